// File: rtl/dmem_arbiter_if.sv
// ---------------------------------------------------------------------------
// dmem_arbiter_if
// Groups the bus signals between the two data-memory requesters (scalar and
// vector), the arbiter and the memory.
//
// Parameters:
//   ADDR_W        address width of both requesters and the memory port
//
// Signal summary:
//   Scalar requester : s_req, s_we, s_addr, s_wdata[15:0], s_rready (to arbiter)
//                      s_gnt, s_rvalid, s_rdata[15:0]              (from arbiter)
//   Vector requester : v_req, v_we, v_addr, v_wdata[255:0], v_rready (to arbiter)
//                      v_gnt, v_rvalid, v_rdata[255:0]              (from arbiter)
//   Memory command   : mem_addr, mem_we, mem_src_sel (0=scalar, 1=vector),
//                      mem_wdata_a[15:0], mem_wdata_b[255:0]        (from arbiter)
//   Memory response  : mem_q_a[15:0], mem_q_b[255:0]                (to arbiter)
//   Status           : busy                                         (from arbiter)
//
// Modports:
//   slave  - the arbiter's view
//   master - the environment's view (requesters plus memory)
// ---------------------------------------------------------------------------
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32
);

  // Scalar requester
  logic              s_req;
  logic              s_we;
  logic [ADDR_W-1:0] s_addr;
  logic [15:0]       s_wdata;
  logic              s_gnt;
  logic              s_rvalid;
  logic [15:0]       s_rdata;
  logic              s_rready;

  // Vector requester
  logic              v_req;
  logic              v_we;
  logic [ADDR_W-1:0] v_addr;
  logic [255:0]      v_wdata;
  logic              v_gnt;
  logic              v_rvalid;
  logic [255:0]      v_rdata;
  logic              v_rready;

  // Memory port
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic              mem_src_sel;
  logic [15:0]       mem_wdata_a;
  logic [255:0]      mem_wdata_b;
  logic [15:0]       mem_q_a;
  logic [255:0]      mem_q_b;

  // Status
  logic              busy;

  modport slave (
    input  s_req, s_we, s_addr, s_wdata, s_rready,
    input  v_req, v_we, v_addr, v_wdata, v_rready,
    input  mem_q_a, mem_q_b,
    output s_gnt, s_rvalid, s_rdata,
    output v_gnt, v_rvalid, v_rdata,
    output mem_addr, mem_we, mem_src_sel, mem_wdata_a, mem_wdata_b,
    output busy
  );

  modport master (
    output s_req, s_we, s_addr, s_wdata, s_rready,
    output v_req, v_we, v_addr, v_wdata, v_rready,
    output mem_q_a, mem_q_b,
    input  s_gnt, s_rvalid, s_rdata,
    input  v_gnt, v_rvalid, v_rdata,
    input  mem_addr, mem_we, mem_src_sel, mem_wdata_a, mem_wdata_b,
    input  busy
  );

endinterface

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
// Shares one single-port data memory between a scalar requester (16-bit
// data) and a vector requester (256-bit data). Writes complete in the grant
// cycle; reads take one extra wait cycle (RD_WAIT) and are then returned
// through a per-requester rvalid/rdata holding register with rready
// back-pressure.
//
// Ports:
//   clk  - sole clock, rising edge
//   rst  - synchronous, active-high reset
//   bus  - dmem_arbiter_if.slave (requesters, memory command/response, busy)
//
// Parameters:
//   ADDR_W - address width (must match the interface instance)
//
// Build option:
//   DMEM_ARB_VEC_PRIO_EN - when defined, the vector requester always wins a
//   contention (fixed priority). When undefined, contention is resolved
//   round-robin: the requester not granted most recently wins.
// ---------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int ADDR_W = 32
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_e;

  state_e       state_q;
  logic         srcVec_q;
  logic         s_rvalid_q;
  logic         v_rvalid_q;
  logic [15:0]  s_rdata_q;
  logic [255:0] v_rdata_q;
`ifndef DMEM_ARB_VEC_PRIO_EN
  logic         lastVec_q;
`endif

  logic              sElig;
  logic              vElig;
  logic              pickVec;
  logic              inIdle;
  logic              sGnt;
  logic              vGnt;
  logic              grantRead;
  logic [ADDR_W-1:0] memAddr;

  // Arbitration. A read is only eligible when its response register is free
  // or being drained this cycle, so a held response is never overwritten.
  // Grants are suppressed during reset and outside IDLE.
  always_comb begin
    sElig = bus.s_req & (bus.s_we | ~s_rvalid_q | bus.s_rready);
    vElig = bus.v_req & (bus.v_we | ~v_rvalid_q | bus.v_rready);
`ifdef DMEM_ARB_VEC_PRIO_EN
    pickVec = vElig;
`else
    pickVec = vElig & (~sElig | ~lastVec_q);
`endif
    inIdle    = (state_q == IDLE) & ~rst;
    sGnt      = inIdle & sElig & ~pickVec;
    vGnt      = inIdle & pickVec;
    grantRead = (sGnt & ~bus.s_we) | (vGnt & ~bus.v_we);
    memAddr   = pickVec ? bus.v_addr : bus.s_addr;
  end

  assign bus.s_gnt       = sGnt;
  assign bus.v_gnt       = vGnt;
  assign bus.mem_addr    = memAddr;
  assign bus.mem_we      = (sGnt & bus.s_we) | (vGnt & bus.v_we);
  assign bus.mem_src_sel = pickVec;
  assign bus.mem_wdata_a = bus.s_wdata;
  assign bus.mem_wdata_b = bus.v_wdata;

  // Response and status outputs read as zero for the whole reset cycle,
  // including the first one before the registers have been cleared.
  assign bus.s_rvalid = s_rvalid_q & ~rst;
  assign bus.v_rvalid = v_rvalid_q & ~rst;
  assign bus.s_rdata  = rst ? 16'h0  : s_rdata_q;
  assign bus.v_rdata  = rst ? 256'h0 : v_rdata_q;
  assign bus.busy     = (state_q == RD_WAIT) & ~rst;

  // FSM plus response registers. A consume clears rvalid; a capture in the
  // same cycle is written afterwards and wins, so rvalid stays set with the
  // new data. Reset in RD_WAIT simply drops the outstanding read.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      srcVec_q   <= 1'b0;
      s_rvalid_q <= 1'b0;
      v_rvalid_q <= 1'b0;
      s_rdata_q  <= 16'h0;
      v_rdata_q  <= 256'h0;
`ifndef DMEM_ARB_VEC_PRIO_EN
      lastVec_q  <= 1'b1;
`endif
    end else begin
      if (bus.s_rready) begin
        s_rvalid_q <= 1'b0;
      end
      if (bus.v_rready) begin
        v_rvalid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (grantRead) begin
            state_q  <= RD_WAIT;
            srcVec_q <= vGnt;
          end
        end
        RD_WAIT: begin
          if (srcVec_q) begin
            v_rdata_q  <= bus.mem_q_b;
            v_rvalid_q <= 1'b1;
          end else begin
            s_rdata_q  <= bus.mem_q_a;
            s_rvalid_q <= 1'b1;
          end
          state_q <= IDLE;
        end
      endcase

`ifndef DMEM_ARB_VEC_PRIO_EN
      if (sGnt) begin
        lastVec_q <= 1'b0;
      end else if (vGnt) begin
        lastVec_q <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed, table-driven bench for dmem_arbiter. Each record holds one
// cycle's inputs and the expected outputs in that cycle. A small
// synchronous memory model (16 entries per side, indexed by addr[3:0])
// answers reads one cycle after the command.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

`ifdef DMEM_ARB_VEC_PRIO_EN
  localparam int VP = 1;
`else
  localparam int VP = 0;
`endif

  typedef struct {
    logic        rst;
    logic        sReq;
    logic        sWe;
    logic [15:0] sAddr;
    logic [15:0] sWdata;
    logic        sRready;
    logic        vReq;
    logic        vWe;
    logic [15:0] vAddr;
    logic [31:0] vWdata;
    logic        vRready;
    logic        eS;
    logic        eV;
    logic        eWe;
    logic        eSel;
    logic        eBusy;
    logic        eSRv;
    logic        eVRv;
    logic        chk;
    logic [15:0] eSRd;
    logic [31:0] eVRd;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   nVec = 0;
  int   miscompares = 0;
  vec_t vecs[$];

  dmem_arbiter_if #(.ADDR_W(32)) bus ();

  dmem_arbiter #(.ADDR_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Memory model: write in the command cycle, registered read data.
  logic [15:0]  smem [16] = '{default: '0};
  logic [255:0] vmem [16] = '{default: '0};

  always @(posedge clk) begin
    if (bus.mem_we) begin
      if (bus.mem_src_sel) vmem[bus.mem_addr[3:0]] <= bus.mem_wdata_b;
      else                 smem[bus.mem_addr[3:0]] <= bus.mem_wdata_a;
    end
    bus.mem_q_a <= smem[bus.mem_addr[3:0]];
    bus.mem_q_b <= vmem[bus.mem_addr[3:0]];
  end

  function automatic vec_t mk(
    input int rst_, sReq, sWe, sAddr, sWdata, sRready,
    input int vReq, vWe, vAddr, vWdata, vRready,
    input int eS, eV, eWe, eSel, eBusy, eSRv, eVRv,
    input int chk, eSRd, eVRd);
    vec_t r;
    r.rst = (rst_ != 0);   r.sReq = (sReq != 0);   r.sWe = (sWe != 0);
    r.sAddr = 16'(sAddr);  r.sWdata = 16'(sWdata); r.sRready = (sRready != 0);
    r.vReq = (vReq != 0);  r.vWe = (vWe != 0);     r.vAddr = 16'(vAddr);
    r.vWdata = 32'(vWdata); r.vRready = (vRready != 0);
    r.eS = (eS != 0);  r.eV = (eV != 0);  r.eWe = (eWe != 0);
    r.eSel = (eSel != 0);  r.eBusy = (eBusy != 0);
    r.eSRv = (eSRv != 0);  r.eVRv = (eVRv != 0);  r.chk = (chk != 0);
    r.eSRd = 16'(eSRd);  r.eVRd = 32'(eVRd);
    return r;
  endfunction

  task automatic applyStimulus(input vec_t v);
    rst          = v.rst;
    bus.s_req    = v.sReq;
    bus.s_we     = v.sWe;
    bus.s_addr   = 32'(v.sAddr);
    bus.s_wdata  = v.sWdata;
    bus.s_rready = v.sRready;
    bus.v_req    = v.vReq;
    bus.v_we     = v.vWe;
    bus.v_addr   = 32'(v.vAddr);
    bus.v_wdata  = {8{v.vWdata}};
    bus.v_rready = v.vRready;
  endtask

  task automatic cmpField(input string nm, input logic [255:0] act,
                          input logic [255:0] exp, input int idx);
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL vec %0d %s: got %0h expected %0h", idx, nm, act, exp);
    end
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    nVec++;
    cmpField("s_gnt",    256'(bus.s_gnt),    256'(v.eS),    idx);
    cmpField("v_gnt",    256'(bus.v_gnt),    256'(v.eV),    idx);
    cmpField("mem_we",   256'(bus.mem_we),   256'(v.eWe),   idx);
    cmpField("busy",     256'(bus.busy),     256'(v.eBusy), idx);
    cmpField("s_rvalid", 256'(bus.s_rvalid), 256'(v.eSRv),  idx);
    cmpField("v_rvalid", 256'(bus.v_rvalid), 256'(v.eVRv),  idx);
    cmpField("wdata_a",  256'(bus.mem_wdata_a), 256'(v.sWdata), idx);
    cmpField("wdata_b",  bus.mem_wdata_b, {8{v.vWdata}}, idx);
    if (v.eS || v.eV) begin
      cmpField("mem_src_sel", 256'(bus.mem_src_sel), 256'(v.eSel), idx);
      cmpField("mem_addr", 256'(bus.mem_addr),
               256'(v.eV ? v.vAddr : v.sAddr), idx);
    end
    if (v.chk) begin
      cmpField("s_rdata", 256'(bus.s_rdata), 256'(v.eSRd), idx);
      cmpField("v_rdata", bus.v_rdata, {8{v.eVRd}}, idx);
    end
  endtask

  task automatic runVec(input vec_t v, input int idx);
    @(posedge clk);
    #1;
    applyStimulus(v);
    @(negedge clk);
    checkOutput(v, idx);
  endtask

  initial begin
    rst = 1'b1;
    bus.s_req = 1'b0; bus.s_we = 1'b0; bus.s_addr = '0; bus.s_wdata = '0;
    bus.s_rready = 1'b0;
    bus.v_req = 1'b0; bus.v_we = 1'b0; bus.v_addr = '0; bus.v_wdata = '0;
    bus.v_rready = 1'b0;

    // Main table: reset, writes, read latency, eligibility, back-pressure,
    // request during RD_WAIT, and back-to-back contended writes.
    vecs.push_back(mk(1, 0,0,0,0,0,            0,0,0,0,0,  0,0,0,0,0,0,0, 1,0,0));
    vecs.push_back(mk(1, 1,1,'h10,'hBEEF,0,    0,0,0,0,0,  0,0,0,0,0,0,0, 1,0,0));
    vecs.push_back(mk(0, 1,1,'h10,'hBEEF,0,    0,0,0,0,0,  1,0,1,0,0,0,0, 0,0,0));
    vecs.push_back(mk(0, 1,0,'h10,0,0,         0,0,0,0,0,  1,0,0,0,0,0,0, 0,0,0));
    vecs.push_back(mk(0, 0,0,0,0,0,  1,1,'h2,'h11223344,0, 0,0,0,0,1,0,0, 0,0,0));
    vecs.push_back(mk(0, 0,0,0,0,0,  1,1,'h2,'h11223344,0, 0,1,1,1,0,1,0, 1,'hBEEF,0));
    vecs.push_back(mk(0, 1,1,'h11,'h1234,0,    0,0,0,0,0,  1,0,1,0,0,1,0, 1,'hBEEF,0));
    vecs.push_back(mk(0, 1,0,'h11,0,0,         0,0,0,0,0,  0,0,0,0,0,1,0, 1,'hBEEF,0));
    vecs.push_back(mk(0, 1,0,'h11,0,1,         0,0,0,0,0,  1,0,0,0,0,1,0, 1,'hBEEF,0));
    vecs.push_back(mk(0, 0,0,0,0,0,            0,0,0,0,0,  0,0,0,0,1,0,0, 0,0,0));
    vecs.push_back(mk(0, 0,0,0,0,0,      1,0,'h2,0,0,      0,1,0,1,0,1,0, 1,'h1234,0));
    vecs.push_back(mk(0, 0,0,0,0,1,            0,0,0,0,0,  0,0,0,0,1,1,0, 1,'h1234,0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0, 0,0,0,0,0,    1,0,'h2,0,0,      0,0,0,0,0,0,1, 1,'h1234,'h11223344));
    vecs.push_back(mk(0, 0,0,0,0,0,      1,0,'h2,0,1,      0,1,0,1,0,0,1, 1,'h1234,'h11223344));
    vecs.push_back(mk(0, 0,0,0,0,0,            0,0,0,0,0,  0,0,0,0,1,0,0, 0,0,0));
    for (int i = 0; i < 2; i++) begin
      vecs.push_back(mk(0, 1,1,'h12,'h5555,0, 1,1,'h3,'hAAAA0000,0,
                        1-VP,VP,1,VP,0,0,1, 1,'h1234,'h11223344));
      vecs.push_back(mk(0, 1,1,'h12,'h5555,0, 1,1,'h3,'hAAAA0000,0,
                        0,1,1,1,0,0,1, 1,'h1234,'h11223344));
    end
    vecs.push_back(mk(0, 0,0,0,0,0,            0,0,0,0,1,  0,0,0,0,0,0,1, 1,'h1234,'h11223344));

    // Contended reads straight after reset: first winner depends on build,
    // the loser is granted two cycles later.
    vecs.push_back(mk(1, 0,0,0,0,0,            0,0,0,0,0,  0,0,0,0,0,0,0, 1,0,0));
    vecs.push_back(mk(0, 1,0,'h10,0,0, 1,0,'h2,0,0, 1-VP,VP,0,VP,0,0,0, 1,0,0));
    vecs.push_back(mk(0, 1,0,'h10,0,0, 1,0,'h2,0,0, 0,0,0,0,1,0,0, 1,0,0));
    vecs.push_back(mk(0, 1,0,'h10,0,0, 1,0,'h2,0,0, VP,1-VP,0,1-VP,0,1-VP,VP,
                      1,(1-VP)*'hBEEF,VP*'h11223344));
    vecs.push_back(mk(0, 1,0,'h10,0,0, 1,0,'h2,0,0, 0,0,0,0,1,1-VP,VP,
                      1,(1-VP)*'hBEEF,VP*'h11223344));
    vecs.push_back(mk(0, 1,0,'h10,0,0, 1,0,'h2,0,0, 0,0,0,0,0,1,1,
                      1,'hBEEF,'h11223344));

    // Reset pulsed while a read is outstanding: the read is discarded.
    vecs.push_back(mk(1, 0,0,0,0,0,            0,0,0,0,0,  0,0,0,0,0,0,0, 1,0,0));
    vecs.push_back(mk(0, 1,0,'h11,0,0,         0,0,0,0,0,  1,0,0,0,0,0,0, 1,0,0));
    vecs.push_back(mk(1, 1,0,'h11,0,0,         0,0,0,0,0,  0,0,0,0,0,0,0, 1,0,0));
    vecs.push_back(mk(0, 0,0,0,0,0,            0,0,0,0,0,  0,0,0,0,0,0,0, 1,0,0));
    vecs.push_back(mk(0, 0,0,0,0,0,            0,0,0,0,0,  0,0,0,0,0,0,0, 1,0,0));

    for (int i = 0; i < vecs.size(); i++) begin
      runVec(vecs[i], i);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32: address width of both requesters and the memory port.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 s_req / v_req  in  1  scalar / vector access request.
REQ-005 s_we / v_we  in  1  request is a write (1) or a read (0).
REQ-006 s_addr / v_addr  in  ADDR_W  request address.
REQ-007 s_wdata  in  16 / v_wdata  in  256  write data.
REQ-008 s_gnt / v_gnt  out  1  request accepted this cycle.
REQ-009 s_rvalid / v_rvalid  out  1  read response held valid.
REQ-010 s_rdata  out  16 / v_rdata  out  256  read response data.
REQ-011 s_rready / v_rready  in  1  requester consumes the response.
REQ-012 mem_addr  out  ADDR_W, mem_we  out  1, mem_src_sel  out  1 (0=scalar, 1=vector): memory command.
REQ-013 mem_wdata_a  out  16, mem_wdata_b  out  256: memory write data.
REQ-014 mem_q_a  in  16, mem_q_b  in  256: memory read data, valid one cycle after the read command.
REQ-015 busy  out  1: high while the FSM is in RD_WAIT.

Function
REQ-016 FSM states: IDLE and RD_WAIT. Only IDLE grants requests.
REQ-017 IDLE: grant at most one requester per cycle. A requester is eligible when req=1 and, if it is a read, its rvalid=0 or its rready=1 in that cycle.
REQ-018 Grant is combinational in the request cycle: gnt=1 drives mem_addr, mem_we=we and mem_src_sel from the winner in the same cycle.
REQ-019 mem_wdata_a and mem_wdata_b always pass s_wdata and v_wdata through. mem_we is 0 in any cycle without a write grant.
REQ-020 A granted write completes in its grant cycle. The FSM stays in IDLE, so back-to-back writes run at one per cycle.
REQ-021 A granted read moves IDLE->RD_WAIT. In RD_WAIT mem_q_a or mem_q_b (selected by the registered source) is captured into that requester's rdata register, rvalid is set, and the FSM returns to IDLE.
REQ-022 Read latency: grant at cycle T, rvalid=1 from T+2. The minimum read-to-read spacing is 2 cycles.
REQ-023 rvalid and rdata hold stable until a cycle in which rready=1, which clears rvalid. A capture and a consume in the same cycle leave rvalid=1 with the new data.
REQ-024 In RD_WAIT, s_gnt=v_gnt=0 and mem_we=0 regardless of requests.
REQ-025 Contention when both are eligible: round-robin. The requester not granted most recently wins. The last-grant register updates on every grant.
REQ-026 A single eligible requester is always granted, independent of last-grant.
REQ-027 Address bits pass unmodified. Truncation to the scalar/vector word index is the memory's responsibility.

Reset
REQ-028 While rst=1: FSM=IDLE, s_rvalid=v_rvalid=0, s_rdata=v_rdata=0, last-grant=vector (scalar wins the first contention), s_gnt=v_gnt=0, mem_we=0, busy=0.
REQ-029 rst asserted in RD_WAIT discards the pending read. No rvalid is produced after reset deasserts.

Configuration
REQ-030 Macro DMEM_ARB_VEC_PRIO_EN defined: fixed priority; on contention the vector requester always wins and last-grant is unused.
REQ-031 DMEM_ARB_VEC_PRIO_EN undefined: round-robin per REQ-025. All other behaviour is identical in both builds.

Verification
REQ-032 Scalar write 0x0010<-0xBEEF, then scalar read 0x0010 -> s_gnt at T, s_rvalid at T+2 with s_rdata=0xBEEF.
REQ-033 s_req=v_req=1 (both reads) after reset -> scalar granted first; vector granted 2 cycles later; with DMEM_ARB_VEC_PRIO_EN, vector first.
REQ-034 Vector read with v_rready=0 for 5 cycles -> v_rvalid and v_rdata stable; a new vector read is not granted until v_rready=1.
REQ-035 Scalar and vector writes on every cycle -> alternating grants, mem_we=1 every cycle, mem_src_sel toggles 0,1,0,1.
REQ-036 rst pulsed one cycle in RD_WAIT -> no rvalid afterwards; busy=0 and FSM in IDLE on the next cycle.
REQ-037 Request arriving during RD_WAIT -> gnt=0 that cycle; granted in the following IDLE cycle.
